// File: rtl/pipelined_cla_adder.sv
// ---------------------------------------------------------------------------
// pipelined_cla_adder
//
// Pipelined carry-lookahead adder. The WIDTH-bit operands are cut into
// NSEG = WIDTH/SEG_W segments. Each segment is added in its own pipeline
// stage by a SEG_W-bit lookahead adder. That adder uses 4-bit generate/propagate
// groups with lookahead at the group level as well. The carry out of each
// stage is registered and feeds the next stage. A beat accepted on clock
// edge t is presented on the output after edge t+NSEG-1.
//
// Optional feature (macro PCLA_SUB_EN):
//   When it is defined, the port 'sub' exists. A beat with sub=1 computes
//   a + ~b + 1 and ignores cin. sum[WIDTH] is then NOT borrow.
//   When it is undefined, the block only adds: a + b + cin.
//
// Ports
//   clk        in   1        rising-edge clock
//   rst_n      in   1        asynchronous active-low reset
//   in_valid   in   1        operand beat valid
//   in_ready   out  1        block can accept a beat this cycle
//   a, b       in   WIDTH    operands (unsigned / two's complement)
//   cin        in   1        carry in
//   sub        in   1        subtract select (PCLA_SUB_EN only)
//   out_valid  out  1        result valid
//   out_ready  in   1        downstream accepts result
//   sum        out  WIDTH+1  {carry_out, sum[WIDTH-1:0]}
//   ovf        out  1        signed overflow (carry into MSB ^ carry out of MSB)
// ---------------------------------------------------------------------------
module pipelined_cla_adder #(
  parameter int WIDTH = 32,
  parameter int SEG_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef PCLA_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum,
  output logic             ovf
);

  localparam int NSEG = WIDTH / SEG_W;
  localparam int NGRP = SEG_W / 4;

  if (SEG_W <= 0 || (SEG_W % 4) != 0) begin : g_bad_seg_w
    $error("pipelined_cla_adder: SEG_W must be a positive multiple of 4");
  end
  if (WIDTH < SEG_W || (WIDTH % SEG_W) != 0) begin : g_bad_width
    $error("pipelined_cla_adder: WIDTH must be a multiple of SEG_W");
  end

  // Returns every bit carry c[0..SEG_W] of one segment.
  // Group carries are written out as a sum of products over the group G/P terms,
  // and not as a ripple between groups. The bit carries inside a group are
  // built the same way from the group carry-in.
  function automatic logic [SEG_W:0] seg_carries(input logic [SEG_W-1:0] g,
                                                 input logic [SEG_W-1:0] p,
                                                 input logic             c0);
    logic [NGRP-1:0] grp_g;
    logic [NGRP-1:0] grp_p;
    logic [NGRP:0]   grp_c;
    logic [SEG_W:0]  c;
    logic            term;
    grp_g = '0;
    grp_p = '0;
    grp_c = '0;
    c     = '0;
    for (int j = 0; j < NGRP; j++) begin
      for (int i = 0; i < 4; i++) begin
        term = g[4*j+i];
        for (int m = i + 1; m < 4; m++) term = term & p[4*j+m];
        grp_g[j] = grp_g[j] | term;
      end
      grp_p[j] = &p[4*j +: 4];
    end
    for (int j = 0; j <= NGRP; j++) begin
      term = c0;
      for (int m = 0; m < j; m++) term = term & grp_p[m];
      grp_c[j] = term;
      for (int i = 0; i < j; i++) begin
        term = grp_g[i];
        for (int m = i + 1; m < j; m++) term = term & grp_p[m];
        grp_c[j] = grp_c[j] | term;
      end
    end
    for (int j = 0; j < NGRP; j++) begin
      for (int i = 0; i < 4; i++) begin
        term = grp_c[j];
        for (int m = 0; m < i; m++) term = term & p[4*j+m];
        c[4*j+i] = term;
        for (int n = 0; n < i; n++) begin
          term = g[4*j+n];
          for (int m = n + 1; m < i; m++) term = term & p[4*j+m];
          c[4*j+i] = c[4*j+i] | term;
        end
      end
    end
    c[SEG_W] = grp_c[NGRP];
    return c;
  endfunction

  // acc holds the finished sum bits below the current segment. Above it,
  // acc holds the operand-A bits that have not been used yet.
  logic [NSEG-1:0][WIDTH-1:0] acc_q, acc_d;
  logic [NSEG-1:0][WIDTH-1:0] b_q, b_d;
  logic [NSEG-1:0]            carry_q, carry_d;
  logic [NSEG-1:0]            valid_q, valid_d;
  logic                       ovf_q, ovf_d;

  logic [NSEG-1:0][WIDTH-1:0] src_acc;
  logic [NSEG-1:0][WIDTH-1:0] src_b;
  logic [NSEG-1:0]            src_cin;
  logic [NSEG-1:0]            src_v;
  logic [WIDTH-1:0]           b_eff;
  logic                       cin_eff;
  logic                       stall;
  logic                       accept;
  logic [SEG_W-1:0]           seg_a;
  logic [SEG_W-1:0]           seg_b;
  logic [SEG_W:0]             seg_c;

  // Subtraction inverts B and forces the carry-in as the beat enters.
  // The inverted operand then flows down the pipe, so each beat keeps its own
  // add/subtract choice without a separate flag.
`ifdef PCLA_SUB_EN
  always_comb begin
    b_eff   = sub ? ~b : b;
    cin_eff = sub ? 1'b1 : cin;
  end
`else
  always_comb begin
    b_eff   = b;
    cin_eff = cin;
  end
`endif

  // The whole pipe freezes as one unit while the output is held. This keeps
  // each beat paired with the carry that was registered for it.
  always_comb begin
    stall    = valid_q[NSEG-1] & ~out_ready;
    in_ready = ~stall;
    accept   = in_valid & in_ready;
  end

  // Stage inputs: stage 0 reads the ports, and every other stage reads the
  // register of the stage before it.
  always_comb begin
    src_acc    = '0;
    src_b      = '0;
    src_cin    = '0;
    src_v      = '0;
    src_acc[0] = a;
    src_b[0]   = b_eff;
    src_cin[0] = cin_eff;
    src_v[0]   = accept;
    for (int k = 1; k < NSEG; k++) begin
      src_acc[k] = acc_q[k-1];
      src_b[k]   = b_q[k-1];
      src_cin[k] = carry_q[k-1];
      src_v[k]   = valid_q[k-1];
    end
  end

  // Each stage adds its own segment and replaces that slice of acc with the sum.
  // Data registers load only for valid beats. While out_valid is low, the
  // output keeps its last result, and X operands never reach the valid path.
  always_comb begin
    acc_d   = acc_q;
    b_d     = b_q;
    carry_d = carry_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    seg_a   = '0;
    seg_b   = '0;
    seg_c   = '0;
    for (int k = 0; k < NSEG; k++) begin
      seg_a = src_acc[k][k*SEG_W +: SEG_W];
      seg_b = src_b[k][k*SEG_W +: SEG_W];
      seg_c = seg_carries(seg_a & seg_b, seg_a ^ seg_b, src_cin[k]);
      if (!stall) begin
        valid_d[k] = src_v[k];
        if (src_v[k]) begin
          acc_d[k]                     = src_acc[k];
          acc_d[k][k*SEG_W +: SEG_W]   = seg_a ^ seg_b ^ seg_c[SEG_W-1:0];
          b_d[k]                       = src_b[k];
          carry_d[k]                   = seg_c[SEG_W];
          if (k == NSEG - 1) ovf_d     = seg_c[SEG_W] ^ seg_c[SEG_W-1];
        end
      end
    end
  end

  // A reset clears every stage. Beats that were in flight are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      b_q     <= '0;
      carry_q <= '0;
      valid_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    out_valid = valid_q[NSEG-1];
    sum       = {carry_q[NSEG-1], acc_q[NSEG-1]};
    ovf       = ovf_q;
  end

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// ---------------------------------------------------------------------------
// tb_pipelined_cla_adder
//
// Scoreboard bench for pipelined_cla_adder (WIDTH=32, SEG_W=16, two stages).
// The stimulus side queues an expected result each time a beat is accepted.
// A monitor runs on the falling edge. It compares the presented output with
// the head of the queue and pops the entry when the output handshake
// completes. Subtraction vectors are added when PCLA_SUB_EN is defined.
// ---------------------------------------------------------------------------
module tb_pipelined_cla_adder;

  localparam int WIDTH = 32;
  localparam int SEG_W = 16;
  localparam int NSEG  = WIDTH / SEG_W;

  typedef struct packed {
    logic [WIDTH:0] s;
    logic           o;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             cin = 1'b0;
  logic             sub = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH:0]   sum;
  logic             ovf;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   lat;

  always #5 clk = ~clk;

  pipelined_cla_adder #(.WIDTH(WIDTH), .SEG_W(SEG_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef PCLA_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .ovf       (ovf)
  );

  function automatic exp_t mk(input logic [WIDTH:0] s, input logic o);
    exp_t e;
    e.s = s;
    e.o = o;
    return e;
  endfunction

  // Plain arithmetic reference: a wide add, then overflow from the operand and result sign bits
  function automatic exp_t model(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                                 input logic tcin, input logic tsub);
    logic [WIDTH-1:0] bb;
    logic [WIDTH:0]   s;
    logic             cc;
    bb = tsub ? ~tb : tb;
    cc = tsub ? 1'b1 : tcin;
    s  = {1'b0, ta} + {1'b0, bb} + {{WIDTH{1'b0}}, cc};
    return mk(s, (ta[WIDTH-1] == bb[WIDTH-1]) && (s[WIDTH-1] != ta[WIDTH-1]));
  endfunction

  task automatic checkOutput(input string name, input logic [WIDTH+1:0] actual,
                             input logic [WIDTH+1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Present one beat, hold it until it is accepted, and record its expected result
  task automatic applyStimulus(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                               input logic tcin, input logic tsub, input exp_t e);
    bit took;
    took = 1'b0;
    a = ta;
    b = tb;
    cin = tcin;
    sub = tsub;
    in_valid = 1'b1;
    for (int n = 0; n < 1000 && !took; n++) begin
      @(negedge clk);
      took = in_ready;
      @(posedge clk);
      #1;
    end
    if (took) exp_q.push_back(e);
    else begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: beat a=%h b=%h never accepted", ta, tb);
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
    a = 'x;
    b = 'x;
    cin = 1'b0;
    sub = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 200 && exp_q.size() != 0; n++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("drain_outstanding", (WIDTH+2)'(exp_q.size()), '0);
  endtask

  // Monitor: on the falling edge, check any presented result. Pop it only
  // when out_ready is high, because that is when the handshake completes.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_output: got sum=%h ovf=%b with no beat outstanding", sum, ovf);
      end else begin
        checkOutput(out_ready ? "result" : "held_result", {sum, ovf}, exp_q[0]);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    idle();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_out_valid", (WIDTH+2)'(out_valid), '0);
    checkOutput("reset_sum", (WIDTH+2)'(sum), '0);
    checkOutput("reset_ovf", (WIDTH+2)'(ovf), '0);
    checkOutput("reset_in_ready", (WIDTH+2)'(in_ready), (WIDTH+2)'(1));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Send a single beat into an empty pipe and measure how long it takes to appear
    applyStimulus(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, mk(33'h1_0000_0000, 1'b0));
    idle();
    lat = 1;
    while (!out_valid && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput("latency", (WIDTH+2)'(lat), (WIDTH+2)'(NSEG));
    drain();

    // Directed beats sent back to back
    applyStimulus(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, mk(33'h0_8000_0000, 1'b1));
    applyStimulus(32'h0000_FFFF, 32'h0000_0000, 1'b1, 1'b0, mk(33'h0_0001_0000, 1'b0));
    applyStimulus(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, mk(33'h1_0000_0000, 1'b1));
    applyStimulus(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, mk(33'h0_2345_6789, 1'b0));
    applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, mk(33'h1_FFFF_FFFF, 1'b0));
    applyStimulus(32'h0000_8000, 32'h0000_8000, 1'b0, 1'b0, mk(33'h0_0001_0000, 1'b0));
    idle();
    drain();

    // Stream of 100 random beats with out_ready held high
    for (int i = 0; i < 100; i++) begin
      logic [WIDTH-1:0] ra, rb;
      logic             rc;
      ra = $urandom();
      rb = $urandom();
      rc = 1'($urandom_range(0, 1));
      applyStimulus(ra, rb, rc, 1'b0, model(ra, rb, rc, 1'b0));
    end
    idle();
    drain();

    // Hold out_ready low for five cycles in the middle of a stream
    fork
      begin
        for (int i = 0; i < 12; i++) begin
          logic [WIDTH-1:0] ra, rb;
          ra = $urandom();
          rb = $urandom();
          applyStimulus(ra, rb, 1'b0, 1'b0, model(ra, rb, 1'b0, 1'b0));
        end
        idle();
      end
      begin
        repeat (4) @(posedge clk);
        #2;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          checkOutput("stall_in_ready", (WIDTH+2)'(in_ready), '0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Assert reset with two beats in flight; nothing stale may come out afterwards
    applyStimulus(32'hDEAD_BEEF, 32'h0000_0001, 1'b0, 1'b0, mk(33'h0_DEAD_BEF0, 1'b0));
    applyStimulus(32'h0BAD_F00D, 32'h0000_0002, 1'b0, 1'b0, mk(33'h0_0BAD_F00F, 1'b0));
    rst_n = 1'b0;
    exp_q.delete();
    idle();
    #1;
    checkOutput("reset_flush_valid", (WIDTH+2)'(out_valid), '0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      checkOutput("no_stale_after_reset", (WIDTH+2)'(out_valid), '0);
    end
    applyStimulus(32'h0000_0003, 32'h0000_0004, 1'b0, 1'b0, mk(33'h0_0000_0007, 1'b0));
    idle();
    drain();

`ifdef PCLA_SUB_EN
    // Subtract beats mixed with add beats; cin must be ignored on subtract beats
    applyStimulus(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, mk(33'h0_FFFF_FFFE, 1'b0));
    applyStimulus(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, mk(33'h1_7FFF_FFFF, 1'b1));
    applyStimulus(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, mk(33'h0_0000_000D, 1'b0));
    applyStimulus(32'h0000_0009, 32'h0000_0009, 1'b0, 1'b1, mk(33'h1_0000_0000, 1'b0));
    for (int i = 0; i < 40; i++) begin
      logic [WIDTH-1:0] ra, rb;
      logic             rc, rs;
      ra = $urandom();
      rb = $urandom();
      rc = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      applyStimulus(ra, rb, rc, rs, model(ra, rb, rc, rs));
    end
    idle();
    drain();
`endif

    repeat (3) @(posedge clk);
    #1;
    checkOutput("final_idle_valid", (WIDTH+2)'(out_valid), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
